// File: rtl/nn_pkg.sv
// Shared definitions for the ECG classifier output stages: activation width,
// saturation mapping and the argmax controller state encoding.
package nn_pkg;
  localparam int ACT_W = 8;
  localparam logic [ACT_W-1:0] ACT_MAX = 8'd255;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SCAN
  } state_t;

  // Node outputs are unsigned and already clamped at zero, so any bit above
  // the activation byte means the value is out of range and saturates.
  function automatic logic [ACT_W-1:0] sat_act(input logic [DATA_W-1:0] x);
    return (x[DATA_W-1:ACT_W] != '0) ? ACT_MAX : x[ACT_W-1:0];
  endfunction
endpackage

// File: rtl/act_max_cmp.sv
// Running-maximum step: a candidate replaces the current best only when it is
// strictly greater, so on ties the earlier (lower) index is kept.
module act_max_cmp
  import nn_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [ACT_W-1:0] cand,
  input  logic [IDX_W-1:0] cand_idx,
  input  logic [ACT_W-1:0] best_in,
  input  logic [IDX_W-1:0] best_idx_in,
  output logic [ACT_W-1:0] best_out,
  output logic [IDX_W-1:0] best_idx_out
);
  always_comb begin
    best_out     = best_in;
    best_idx_out = best_idx_in;
    if (cand > best_in) begin
      best_out     = cand;
      best_idx_out = cand_idx;
    end
  end
endmodule

// File: rtl/out_layer_argmax.sv
// Final decision stage: waits for the node pipeline to settle, snapshots all
// output-layer nodes, then scans them one per cycle to find the winning class.
module out_layer_argmax #(
  parameter int NUM_NODES = 6,
  parameter int DATA_W    = 24,
  parameter int SETTLE    = 3,
  parameter int IDX_W     = $clog2(NUM_NODES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_NODES*DATA_W-1:0] nodes_in,
  output logic                        busy,
  output logic                        valid,
  output logic [IDX_W-1:0]            class_idx,
  output logic [7:0]                  class_score
);
  import nn_pkg::*;

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [ACT_W-1:0]  best_q, best_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [DATA_W-1:0] snap_q [NUM_NODES];
  logic [DATA_W-1:0] snap_d [NUM_NODES];
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  class_idx_q, class_idx_d;
  logic [ACT_W-1:0]  class_score_q, class_score_d;

  logic [ACT_W-1:0]  cand;
  logic [ACT_W-1:0]  cmp_best;
  logic [IDX_W-1:0]  cmp_idx;

  assign cand = sat_act(snap_q[i_q]);

  act_max_cmp #(.IDX_W(IDX_W)) u_cmp (
    .cand        (cand),
    .cand_idx    (i_q),
    .best_in     (best_q),
    .best_idx_in (best_idx_q),
    .best_out    (cmp_best),
    .best_idx_out(cmp_idx)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    i_d           = i_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    snap_d        = snap_q;
    busy_d        = busy_q;
    valid_d       = 1'b0;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(SETTLE - 1);
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          for (int k = 0; k < NUM_NODES; k++) begin
            snap_d[k] = nodes_in[k*DATA_W +: DATA_W];
          end
          best_d     = '0;
          best_idx_d = '0;
          i_d        = '0;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SCAN: begin
        best_d     = cmp_best;
        best_idx_d = cmp_idx;
        // The last node's comparison feeds the result registers directly,
        // saving a cycle compared with publishing from best_q.
        if (i_q == IDX_W'(NUM_NODES - 1)) begin
          class_idx_d   = cmp_idx;
          class_score_d = cmp_best;
          valid_d       = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      i_q           <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      for (int k = 0; k < NUM_NODES; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      i_q           <= i_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      snap_q        <= snap_d;
    end
  end

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
endmodule

// File: tb/tb_out_layer_argmax.sv
// Scenario bench for out_layer_argmax: expected results are queued when an
// operation starts and popped when the DUT raises valid.
module tb_out_layer_argmax;
  localparam int NUM_NODES = 6;
  localparam int DATA_W    = 24;
  localparam int SETTLE    = 3;
  localparam int IDX_W     = 3;
  localparam int LAT       = SETTLE + NUM_NODES;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [7:0]       score;
  } exp_t;

  logic                        clk;
  logic                        reset;
  logic                        start;
  logic [NUM_NODES*DATA_W-1:0] nodes_in;
  logic                        busy;
  logic                        valid;
  logic [IDX_W-1:0]            class_idx;
  logic [7:0]                  class_score;

  exp_t             sb [$];
  int               checks = 0;
  int               errors = 0;
  int               valid_count = 0;
  logic [IDX_W-1:0] last_idx = '0;
  logic [7:0]       last_score = '0;

  out_layer_argmax #(
    .NUM_NODES(NUM_NODES),
    .DATA_W   (DATA_W),
    .SETTLE   (SETTLE),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .nodes_in   (nodes_in),
    .busy       (busy),
    .valid      (valid),
    .class_idx  (class_idx),
    .class_score(class_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) valid_count++;
  end

  function automatic logic [NUM_NODES*DATA_W-1:0] pk(input int n0, input int n1,
      input int n2, input int n3, input int n4, input int n5);
    return {24'(n5), 24'(n4), 24'(n3), 24'(n2), 24'(n1), 24'(n0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse; on return the accepting edge t0 has just passed.
  task automatic start_op(input logic [NUM_NODES*DATA_W-1:0] nv, input int idx,
                          input int score, input bit push);
    exp_t e;
    nodes_in = nv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    if (push) begin
      e.idx   = IDX_W'(idx);
      e.score = 8'(score);
      sb.push_back(e);
    end
  endtask

  // Waits for valid (bounded), checking busy and result hold on the way,
  // then checks latency and pops the scoreboard.
  task automatic wait_result(input int exp_edges, input string name);
    exp_t e;
    int   n = 0;
    while (valid !== 1'b1 && n < 3 * LAT) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: got %b want 1 at edge +%0d", name, busy, n);
      end
      checks++;
      if (class_idx !== last_idx || class_score !== last_score) begin
        errors++;
        $display("FAIL %s hold: got idx %0d score %0d want idx %0d score %0d",
                 name, class_idx, class_score, last_idx, last_score);
      end
      tick();
      n++;
    end
    checks++;
    if (valid !== 1'b1 || n != exp_edges) begin
      errors++;
      $display("FAIL %s latency: valid %b after %0d edges want 1 after %0d",
               name, valid, n, exp_edges);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_valid: got %b want 0", name, busy);
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: queue empty, got idx %0d score %0d",
               name, class_idx, class_score);
    end else begin
      e = sb.pop_front();
      checks++;
      if (class_idx !== e.idx || class_score !== e.score) begin
        errors++;
        $display("FAIL %s result: got idx %0d score %0d want idx %0d score %0d",
                 name, class_idx, class_score, e.idx, e.score);
      end
      last_idx   = e.idx;
      last_score = e.score;
    end
    $display("txn %s: idx %0d score %0d after %0d edges", name, class_idx,
             class_score, n);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b1;
    nodes_in = pk(5, 9, 1, 2, 3, 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || class_idx !== '0 || class_score !== '0) begin
        errors++;
        $display("FAIL reset_hold: got busy %b valid %b idx %0d score %0d want all 0",
                 busy, valid, class_idx, class_score);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: got busy %b valid %b want 0 0", busy, valid);
    end
    $display("txn reset: busy %b valid %b idx %0d score %0d", busy, valid,
             class_idx, class_score);
  endtask

  task automatic test_basic();
    start_op(pk(10, 200, 35, 7, 199, 0), 1, 200, 1'b1);
    wait_result(LAT, "basic");
  endtask

  task automatic test_tie_zero();
    tick();
    start_op(pk(50, 90, 90, 3, 0, 0), 1, 90, 1'b1);
    wait_result(LAT, "tie");
    tick();
    start_op(pk(0, 0, 0, 0, 0, 0), 0, 0, 1'b1);
    wait_result(LAT, "all_zero");
  endtask

  task automatic test_sat_snapshot();
    int vc0;
    tick();
    start_op(pk(12, 254, 0, 24'h000100, 200, 100), 3, 255, 1'b1);
    tick();
    tick();
    tick();
    // snapshot edge t0+3 has passed: later input changes must not matter
    nodes_in = pk(254, 254, 254, 254, 254, 254);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vc0 = valid_count;
    wait_result(LAT - 5, "saturate");
    for (int k = 0; k < 2 * LAT; k++) tick();
    checks++;
    if (valid_count != vc0 + 1) begin
      errors++;
      $display("FAIL ignored_start: got %0d valid pulses want 1", valid_count - vc0);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    start_op(pk(3, 4, 5, 6, 100, 2), 4, 100, 1'b1);
    wait_result(LAT, "b2b_first");
    start_op(pk(0, 0, 0, 0, 0, 77), 5, 77, 1'b1);
    wait_result(LAT, "b2b_second");
  endtask

  task automatic test_reset_mid_scan();
    int vc0;
    tick();
    start_op(pk(1, 2, 3, 4, 5, 6), 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || class_idx !== '0 || class_score !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: got busy %b valid %b idx %0d score %0d want all 0",
               busy, valid, class_idx, class_score);
    end
    last_idx   = '0;
    last_score = '0;
    vc0 = valid_count;
    for (int k = 0; k < 2 * LAT; k++) tick();
    checks++;
    if (valid_count != vc0) begin
      errors++;
      $display("FAIL mid_reset_no_valid: got %0d valid pulses want 0", valid_count - vc0);
    end
    $display("txn mid_reset: busy %b valid %b idx %0d score %0d", busy, valid,
             class_idx, class_score);
    start_op(pk(9, 8, 7, 6, 5, 40), 5, 40, 1'b1);
    wait_result(LAT, "after_reset");
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    nodes_in = '0;
    test_reset();
    test_basic();
    test_tie_zero();
    test_sat_snapshot();
    test_back_to_back();
    test_reset_mid_scan();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d queued results want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
